i2c_reg_bank: RTL and testbench
===============================

# i2c_reg_bank

Clocked register bank that sits directly downstream of the I2C slave and consumes its address/data handshake. It synchronises the slave's ARDY/DRDY strobes into the system clock domain and interprets the first written byte of a transaction as a register pointer. It commits subsequent written bytes to an 8-bit register array, or supplies read bytes on IDATA, with optional pointer auto-increment. It drives ACKA_RDY/ACKD_RDY so the slave stretches SCL until each byte is handled.

## Interface
- DEV_ADDR, 7'h42: 7-bit device address this bank answers to.
- NREGS, 16: number of 8-bit registers; power of two, 2..256.
- PTR_W, $clog2(NREGS): pointer width (derived, not overridden).
- CLK  in  1  system clock, all state on rising edge.
- NRST  in  1  asynchronous active-low reset.
- ADDR  in  7  address from slave, stable while ARDY high.
- RW  in  1  0 = master write, 1 = master read; stable while ARDY high.
- ARDY  in  1  address+RW received (SCL domain, level).
- ODATA  in  8  written byte from slave, stable while DRDY high.
- DRDY  in  1  byte boundary reached (SCL domain, level).
- IDATA  out  8  byte the slave shifts out on a master read.
- ACKA_RDY  out  1  address phase handled; slave releases SCL.
- ACKD_RDY  out  1  data phase handled; slave releases SCL.
- REGS  out  8*NREGS  flattened register array, reg i at [8i+7:8i].
- WR_STROBE  out  1  one-CLK pulse per committed register write.
- WR_IDX  out  PTR_W  index of the last committed register.
- SEL  out  1  current transaction addressed this bank.

## Operation
- ARDY and DRDY each pass through a two-flop synchroniser; rising/falling edges are detected on the synchronised level.
- FSM states: IDLE, A_HOLD, D_HOLD.
- IDLE: on synced ARDY rise, set SEL = (ADDR == DEV_ADDR) and latch RW. Set first_byte = 1. If SEL and RW = 1, load IDATA = reg[ptr]. Assert ACKA_RDY and go to A_HOLD.
- A_HOLD: hold ACKA_RDY until synced ARDY falls, then drop ACKA_RDY and go to IDLE.
- IDLE: on synced DRDY rise, process the byte, assert ACKD_RDY and go to D_HOLD.
  - SEL and RW = 0 and first_byte: ptr = ODATA[PTR_W-1:0]; first_byte = 0; no register write.
  - SEL and RW = 0 and not first_byte: reg[ptr] = ODATA; WR_STROBE pulse; WR_IDX = ptr; advance ptr.
  - SEL and RW = 1: advance ptr, then IDATA = reg[new ptr], prefetching the next read byte.
  - SEL = 0: no state change, handshake only. A non-matching address never stalls the bus.
- D_HOLD: hold ACKD_RDY until synced DRDY falls, then drop it and go to IDLE.
- Pointer advance is modulo NREGS (wrap 15 -> 0 for the default).
- Pointer bits of ODATA above PTR_W are ignored.
- ptr persists across transactions; a read without a preceding pointer write starts at the last ptr.
- If synced ARDY and DRDY rise in the same cycle, ARDY wins and DRDY is handled next from IDLE.
- Reset while mid-handshake: outputs return to reset values immediately. The FSM resumes in IDLE, and a still-high ARDY/DRDY is not re-detected until its next rising edge.
- Reset values: IDATA 0, ACKA_RDY 0, ACKD_RDY 0, REGS all 0, WR_STROBE 0, WR_IDX 0, SEL 0, ptr 0, first_byte 1.

## Timing
- ARDY/DRDY rise to ACKA_RDY/ACKD_RDY rise: 3 CLK cycles (2 synchroniser + 1 register).
- ARDY/DRDY fall to ACK output fall: 3 CLK cycles.
- IDATA and REGS update in the same cycle the ACK output rises, so data is stable before the slave releases SCL.
- WR_STROBE is high exactly one cycle, coincident with the ACKD_RDY rise.
- No CLK/SCL frequency ratio is required; correctness relies on the slave stretching SCL.

## Configuration
- I2C_REG_BANK_AUTOINC_EN defined: ptr advances after every data byte as above.
- Not defined: ptr changes only on a pointer write.
  - Repeated writes all target the same register.
  - Repeated reads return the same register each byte.

## Structure
- Shared package i2c_pkg: RW_WRITE/RW_READ constants and the FSM state encoding.
- Sub-module sync_2ff (1-bit, CLK/NRST): instantiated for ARDY and DRDY.

## Test plan
- Write addr 0x42, bytes 0x03, 0xA5, 0x5A -> reg3 = 0xA5, reg4 = 0x5A; two WR_STROBE pulses with WR_IDX 3 then 4; ptr = 5.
- Preload reg7 = 0x11, reg8 = 0x22; write ptr 0x07, then read 2 bytes -> IDATA 0x11 then 0x22.
- Write ptr 0x0F, then bytes 0x01, 0x02 -> reg15 = 0x01, reg0 = 0x02 (wrap).
- Address 0x10 write of 0x00, 0xFF -> ACKA_RDY/ACKD_RDY still toggle with 3-cycle latency, SEL = 0, REGS unchanged, no WR_STROBE.
- Drop NRST while ACKD_RDY high -> all outputs return to reset values; the next ARDY rise is handled normally.
- Without I2C_REG_BANK_AUTOINC_EN: ptr 0x02 then bytes 0x10, 0x20 -> reg2 = 0x20, reg3 unchanged.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register bank.
//   RW_WRITE / RW_READ : meaning of the RW bit sampled in the address phase
//   state_t            : handshake FSM state encoding
package i2c_pkg;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_A_HOLD = 2'd1,
    ST_D_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/i2c_reg_bank_if.sv
// Address/data handshake between the I2C slave shifter and the register bank.
//   ADDR/RW/ARDY  : address phase, driven by the shifter (ARDY is SCL-domain)
//   ODATA/DRDY    : written byte and byte boundary, driven by the shifter
//   IDATA         : byte returned to the shifter on a master read
//   ACKA_RDY      : address phase handled, shifter may release SCL
//   ACKD_RDY      : data phase handled, shifter may release SCL
// Modports: master = shifter side, slave = register bank side.
interface i2c_reg_bank_if;
  logic [6:0] ADDR;
  logic       RW;
  logic       ARDY;
  logic [7:0] ODATA;
  logic       DRDY;
  logic [7:0] IDATA;
  logic       ACKA_RDY;
  logic       ACKD_RDY;

  modport master (
    output ADDR, RW, ARDY, ODATA, DRDY,
    input  IDATA, ACKA_RDY, ACKD_RDY
  );

  modport slave (
    input  ADDR, RW, ARDY, ODATA, DRDY,
    output IDATA, ACKA_RDY, ACKD_RDY
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop level synchroniser for a single bit.
//   CLK     : destination clock
//   NRST    : asynchronous active-low reset, both flops load RST_VAL
//   i_d     : asynchronous input level
//   o_q     : synchronised level, two CLK cycles behind i_d
module sync_2ff #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic NRST,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/i2c_reg_bank.sv
// I2C register bank: consumes the slave shifter's ARDY/DRDY handshake in the
// CLK domain. The first written byte of a transaction is the register pointer;
// later written bytes are committed to the register array, read bytes are
// supplied on IDATA. ACKA_RDY/ACKD_RDY hold SCL stretched until each phase is
// handled.
//   CLK, NRST  : system clock, asynchronous active-low reset
//   bus        : i2c_reg_bank_if.slave handshake
//   REGS       : flattened register array, reg i at [8i+7:8i]
//   WR_STROBE  : one-cycle pulse per committed register write
//   WR_IDX     : index of the last committed register
//   SEL        : current transaction addressed this bank
// Build option: define I2C_REG_BANK_AUTOINC_EN to advance the pointer after
// every data byte; otherwise the pointer only changes on a pointer write.
//
// state     | meaning
// ST_IDLE   | waiting for a synced ARDY or DRDY rising edge
// ST_A_HOLD | address handled, ACKA_RDY high until synced ARDY falls
// ST_D_HOLD | data byte handled, ACKD_RDY high until synced DRDY falls
module i2c_reg_bank #(
  parameter logic [6:0] DEV_ADDR = 7'h42,
  parameter int         NREGS    = 16,
  localparam int        PTR_W    = $clog2(NREGS)
) (
  input  logic                 CLK,
  input  logic                 NRST,
  i2c_reg_bank_if.slave        bus,
  output logic [8*NREGS-1:0]   REGS,
  output logic                 WR_STROBE,
  output logic [PTR_W-1:0]     WR_IDX,
  output logic                 SEL
);
  import i2c_pkg::*;

  logic w_ardy_s, w_drdy_s;
  logic r_ardy_q, r_drdy_q;
  logic w_ardy_rise, w_ardy_fall, w_drdy_rise, w_drdy_fall;

  state_t r_state, w_state_nxt;
  logic   w_do_addr, w_do_data;
  logic   r_dpend;

  logic [7:0]       r_regs [NREGS];
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_adv;
  logic             r_first;
  logic             r_sel;
  logic             r_rw;
  logic [7:0]       r_idata;
  logic             r_wr_strobe;
  logic [PTR_W-1:0] r_wr_idx;
  logic             w_addr_match;

  // Synchronisers and edge flops reset high: a strobe still high across reset
  // then looks like a steady level, and only its next rising edge is seen.
  sync_2ff #(.RST_VAL(1'b1)) u_sync_ardy (
    .CLK(CLK), .NRST(NRST), .i_d(bus.ARDY), .o_q(w_ardy_s)
  );
  sync_2ff #(.RST_VAL(1'b1)) u_sync_drdy (
    .CLK(CLK), .NRST(NRST), .i_d(bus.DRDY), .o_q(w_drdy_s)
  );

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_ardy_q <= 1'b1;
      r_drdy_q <= 1'b1;
    end else begin
      r_ardy_q <= w_ardy_s;
      r_drdy_q <= w_drdy_s;
    end
  end

  assign w_ardy_rise =  w_ardy_s & ~r_ardy_q;
  assign w_ardy_fall = ~w_ardy_s &  r_ardy_q;
  assign w_drdy_rise =  w_drdy_s & ~r_drdy_q;
  assign w_drdy_fall = ~w_drdy_s &  r_drdy_q;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_do_addr   = 1'b0;
    w_do_data   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ardy_rise) begin
          w_do_addr   = 1'b1;
          w_state_nxt = ST_A_HOLD;
        end else if (w_drdy_rise || r_dpend) begin
          w_do_data   = 1'b1;
          w_state_nxt = ST_D_HOLD;
        end
      end
      ST_A_HOLD: if (w_ardy_fall) w_state_nxt = ST_IDLE;
      ST_D_HOLD: if (w_drdy_fall) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // A DRDY edge that arrives while the address phase is still being held
  // (or together with it) is remembered and serviced on return to IDLE.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST)            r_dpend <= 1'b0;
    else if (w_do_data)   r_dpend <= 1'b0;
    else if (w_drdy_rise) r_dpend <= 1'b1;
    else if (w_drdy_fall) r_dpend <= 1'b0;
  end

`ifdef I2C_REG_BANK_AUTOINC_EN
  assign w_ptr_adv = r_ptr + PTR_W'(1);
`else
  assign w_ptr_adv = r_ptr;
`endif

  assign w_addr_match = (bus.ADDR == DEV_ADDR);

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_ptr       <= '0;
      r_first     <= 1'b1;
      r_sel       <= 1'b0;
      r_rw        <= RW_WRITE;
      r_idata     <= '0;
      r_wr_strobe <= 1'b0;
      r_wr_idx    <= '0;
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_do_addr) begin
        r_sel   <= w_addr_match;
        r_rw    <= bus.RW;
        r_first <= 1'b1;
        if (w_addr_match && bus.RW == RW_READ) r_idata <= r_regs[r_ptr];
      end else if (w_do_data && r_sel) begin
        if (r_rw == RW_WRITE) begin
          if (r_first) begin
            r_ptr   <= bus.ODATA[PTR_W-1:0];
            r_first <= 1'b0;
          end else begin
            r_regs[r_ptr] <= bus.ODATA;
            r_wr_strobe   <= 1'b1;
            r_wr_idx      <= r_ptr;
            r_ptr         <= w_ptr_adv;
          end
        end else begin
          // Prefetch the byte the master will clock out next.
          r_ptr   <= w_ptr_adv;
          r_idata <= r_regs[w_ptr_adv];
        end
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign REGS[8*g +: 8] = r_regs[g];
  end

  assign bus.IDATA    = r_idata;
  assign bus.ACKA_RDY = (r_state == ST_A_HOLD);
  assign bus.ACKD_RDY = (r_state == ST_D_HOLD);
  assign WR_STROBE    = r_wr_strobe;
  assign WR_IDX       = r_wr_idx;
  assign SEL          = r_sel;

endmodule

// File: tb/tb_i2c_reg_bank.sv
module tb_i2c_reg_bank;

`ifdef I2C_REG_BANK_AUTOINC_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         NRST;
  logic [127:0] REGS;
  logic         WR_STROBE;
  logic [3:0]   WR_IDX;
  logic         SEL;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  i2c_reg_bank_if bus ();

  i2c_reg_bank #(.DEV_ADDR(7'h42), .NREGS(16)) dut (
    .CLK(CLK), .NRST(NRST), .bus(bus),
    .REGS(REGS), .WR_STROBE(WR_STROBE), .WR_IDX(WR_IDX), .SEL(SEL)
  );

  typedef struct {
    bit         is_addr;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] odata;
    bit         exp_sel;
    bit         chk_idata;
    logic [7:0] exp_idata;
    bit         exp_stb;
    logic [3:0] exp_idx;
    int         reg_i;
    logic [7:0] reg_v;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic ack(input bit a);
    return a ? bus.ACKA_RDY : bus.ACKD_RDY;
  endfunction

  function automatic vec_t va(input logic [6:0] a, input logic rw, input bit sel,
                              input bit ci, input logic [7:0] ei,
                              input int ri, input logic [7:0] rv);
    vec_t v;
    v.is_addr = 1'b1; v.addr = a; v.rw = rw; v.odata = 8'h00;
    v.exp_sel = sel; v.chk_idata = ci; v.exp_idata = ei;
    v.exp_stb = 1'b0; v.exp_idx = 4'h0; v.reg_i = ri; v.reg_v = rv;
    return v;
  endfunction

  function automatic vec_t vd(input logic [7:0] d, input bit sel, input bit ci,
                              input logic [7:0] ei, input bit stb, input logic [3:0] idx,
                              input int ri, input logic [7:0] rv);
    vec_t v;
    v.is_addr = 1'b0; v.addr = 7'h00; v.rw = 1'b0; v.odata = d;
    v.exp_sel = sel; v.chk_idata = ci; v.exp_idata = ei;
    v.exp_stb = stb; v.exp_idx = idx; v.reg_i = ri; v.reg_v = rv;
    return v;
  endfunction

  // One complete handshake phase: strobe high, ACK after exactly 3 cycles,
  // strobe low, ACK drops after exactly 3 cycles.
  task automatic do_step(input vec_t v, input string nm);
    @(negedge CLK);
    if (v.is_addr) begin
      bus.ADDR = v.addr; bus.RW = v.rw; bus.ARDY = 1'b1;
    end else begin
      bus.ODATA = v.odata; bus.DRDY = 1'b1;
    end
    repeat (2) @(posedge CLK);
    #1 chk({nm, " ack_early"}, 32'(ack(v.is_addr)), 32'd0);
    @(posedge CLK);
    #1 chk({nm, " ack_rise"}, 32'(ack(v.is_addr)), 32'd1);
    chk({nm, " sel"}, 32'(SEL), 32'(v.exp_sel));
    chk({nm, " strobe"}, 32'(WR_STROBE), 32'(v.exp_stb));
    if (v.chk_idata) chk({nm, " idata"}, 32'(bus.IDATA), 32'(v.exp_idata));
    if (v.exp_stb)   chk({nm, " wr_idx"}, 32'(WR_IDX), 32'(v.exp_idx));
    if (v.reg_i >= 0) chk({nm, " reg"}, 32'(REGS[v.reg_i*8 +: 8]), 32'(v.reg_v));
    @(posedge CLK);
    #1 chk({nm, " strobe_end"}, 32'(WR_STROBE), 32'd0);
    @(negedge CLK);
    if (v.is_addr) bus.ARDY = 1'b0;
    else           bus.DRDY = 1'b0;
    repeat (2) @(posedge CLK);
    #1 chk({nm, " ack_hold"}, 32'(ack(v.is_addr)), 32'd1);
    @(posedge CLK);
    #1 chk({nm, " ack_fall"}, 32'(ack(v.is_addr)), 32'd0);
  endtask

  initial begin
    bus.ADDR = 7'h00; bus.RW = 1'b0; bus.ARDY = 1'b0;
    bus.ODATA = 8'h00; bus.DRDY = 1'b0;
    NRST = 1'b0;

    // Pointer write + two data bytes
    tbl.push_back(va(7'h42, 1'b0, 1, 0, 8'h00, -1, 8'h00));
    tbl.push_back(vd(8'h03, 1, 0, 8'h00, 0, 4'h0, -1, 8'h00));
    tbl.push_back(vd(8'hA5, 1, 0, 8'h00, 1, 4'h3, 3, 8'hA5));
    tbl.push_back(vd(8'h5A, 1, 0, 8'h00, 1, AI ? 4'h4 : 4'h3, AI ? 4 : 3, 8'h5A));
    // Preload reg7 = 0x11 and reg8 = 0x22 (pointer 0xF8: upper bits ignored)
    tbl.push_back(va(7'h42, 1'b0, 1, 0, 8'h00, -1, 8'h00));
    tbl.push_back(vd(8'h07, 1, 0, 8'h00, 0, 4'h0, -1, 8'h00));
    tbl.push_back(vd(8'h11, 1, 0, 8'h00, 1, 4'h7, 7, 8'h11));
    tbl.push_back(va(7'h42, 1'b0, 1, 0, 8'h00, -1, 8'h00));
    tbl.push_back(vd(8'hF8, 1, 0, 8'h00, 0, 4'h0, -1, 8'h00));
    tbl.push_back(vd(8'h22, 1, 0, 8'h00, 1, 4'h8, 8, 8'h22));
    // Pointer 7 then read two bytes
    tbl.push_back(va(7'h42, 1'b0, 1, 0, 8'h00, -1, 8'h00));
    tbl.push_back(vd(8'h07, 1, 0, 8'h00, 0, 4'h0, -1, 8'h00));
    tbl.push_back(va(7'h42, 1'b1, 1, 1, 8'h11, -1, 8'h00));
    tbl.push_back(vd(8'hFF, 1, 1, AI ? 8'h22 : 8'h11, 0, 4'h0, -1, 8'h00));
    // Wrap 15 -> 0
    tbl.push_back(va(7'h42, 1'b0, 1, 0, 8'h00, -1, 8'h00));
    tbl.push_back(vd(8'h0F, 1, 0, 8'h00, 0, 4'h0, -1, 8'h00));
    tbl.push_back(vd(8'h01, 1, 0, 8'h00, 1, 4'hF, 15, 8'h01));
    tbl.push_back(vd(8'h02, 1, 0, 8'h00, 1, AI ? 4'h0 : 4'hF, AI ? 0 : 15, 8'h02));
    // Foreign address: handshake only
    tbl.push_back(va(7'h10, 1'b0, 0, 0, 8'h00, -1, 8'h00));
    tbl.push_back(vd(8'h00, 0, 0, 8'h00, 0, 4'h0, 0, AI ? 8'h02 : 8'h00));
    tbl.push_back(vd(8'hFF, 0, 0, 8'h00, 0, 4'h0, 15, AI ? 8'h01 : 8'h02));
    // Pointer 2, bytes 0x10 0x20
    tbl.push_back(va(7'h42, 1'b0, 1, 0, 8'h00, -1, 8'h00));
    tbl.push_back(vd(8'h02, 1, 0, 8'h00, 0, 4'h0, -1, 8'h00));
    tbl.push_back(vd(8'h10, 1, 0, 8'h00, 1, 4'h2, 2, 8'h10));
    tbl.push_back(vd(8'h20, 1, 0, 8'h00, 1, AI ? 4'h3 : 4'h2, AI ? 3 : 2, 8'h20));
    // Read without pointer write starts at the persisted pointer
    tbl.push_back(va(7'h42, 1'b1, 1, 1, AI ? 8'h5A : 8'h20, 3, AI ? 8'h20 : 8'h5A));

    #1;
    chk("rst acka",  32'(bus.ACKA_RDY), 32'd0);
    chk("rst ackd",  32'(bus.ACKD_RDY), 32'd0);
    chk("rst idata", 32'(bus.IDATA), 32'd0);
    chk("rst regs",  32'(|REGS), 32'd0);
    chk("rst strobe", 32'(WR_STROBE), 32'd0);
    chk("rst wr_idx", 32'(WR_IDX), 32'd0);
    chk("rst sel",   32'(SEL), 32'd0);
    repeat (3) @(negedge CLK);
    NRST = 1'b1;
    repeat (4) @(negedge CLK);

    for (int i = 0; i < tbl.size(); i++) do_step(tbl[i], $sformatf("v%0d", i));

    // ARDY and DRDY rise together: address first, byte (pointer 5) afterwards
    @(negedge CLK);
    bus.ADDR = 7'h42; bus.RW = 1'b0; bus.ODATA = 8'h05;
    bus.ARDY = 1'b1; bus.DRDY = 1'b1;
    repeat (3) @(posedge CLK);
    #1 chk("sim acka", 32'(bus.ACKA_RDY), 32'd1);
    chk("sim ackd_wait", 32'(bus.ACKD_RDY), 32'd0);
    repeat (2) @(posedge CLK);
    #1 chk("sim ackd_held", 32'(bus.ACKD_RDY), 32'd0);
    @(negedge CLK);
    bus.ARDY = 1'b0;
    repeat (3) @(posedge CLK);
    #1 chk("sim acka_fall", 32'(bus.ACKA_RDY), 32'd0);
    chk("sim ackd_idle", 32'(bus.ACKD_RDY), 32'd0);
    @(posedge CLK);
    #1 chk("sim ackd_rise", 32'(bus.ACKD_RDY), 32'd1);
    chk("sim no_strobe", 32'(WR_STROBE), 32'd0);
    @(negedge CLK);
    bus.DRDY = 1'b0;
    repeat (3) @(posedge CLK);
    #1 chk("sim ackd_fall", 32'(bus.ACKD_RDY), 32'd0);
    do_step(vd(8'h77, 1, 0, 8'h00, 1, 4'h5, 5, 8'h77), "sim byte");

    // Reset while ACKD_RDY is high
    do_step(va(7'h42, 1'b0, 1, 0, 8'h00, -1, 8'h00), "mr addr");
    do_step(vd(8'h01, 1, 0, 8'h00, 0, 4'h0, -1, 8'h00), "mr ptr");
    @(negedge CLK);
    bus.ODATA = 8'h99; bus.DRDY = 1'b1;
    repeat (3) @(posedge CLK);
    #1 chk("mr ackd", 32'(bus.ACKD_RDY), 32'd1);
    chk("mr strobe", 32'(WR_STROBE), 32'd1);
    @(negedge CLK);
    NRST = 1'b0;
    #1;
    chk("mr rst ackd",  32'(bus.ACKD_RDY), 32'd0);
    chk("mr rst acka",  32'(bus.ACKA_RDY), 32'd0);
    chk("mr rst sel",   32'(SEL), 32'd0);
    chk("mr rst idata", 32'(bus.IDATA), 32'd0);
    chk("mr rst strobe", 32'(WR_STROBE), 32'd0);
    chk("mr rst wr_idx", 32'(WR_IDX), 32'd0);
    chk("mr rst regs",  32'(|REGS), 32'd0);
    @(negedge CLK);
    NRST = 1'b1;
    repeat (6) @(posedge CLK);
    #1 chk("mr no_redetect", 32'(bus.ACKD_RDY), 32'd0);
    @(negedge CLK);
    bus.DRDY = 1'b0;
    repeat (4) @(negedge CLK);
    do_step(va(7'h42, 1'b0, 1, 0, 8'h00, -1, 8'h00), "mr2 addr");
    do_step(vd(8'h06, 1, 0, 8'h00, 0, 4'h0, -1, 8'h00), "mr2 ptr");
    do_step(vd(8'h3C, 1, 0, 8'h00, 1, 4'h6, 6, 8'h3C), "mr2 byte");
    chk("mr2 reg1_cleared", 32'(REGS[8 +: 8]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
